// File: rtl/gmii_rx_frame_ctrl_pkg.sv
// Shared types and constants for the GMII receive frame controller (package eth_rx_pkg).
package eth_rx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_DATA, ST_CHECK, ST_STATUS, ST_DROP
  } state_t;

  localparam logic [2:0] STAT_OK      = 3'd0;
  localparam logic [2:0] STAT_CRC     = 3'd1;
  localparam logic [2:0] STAT_RUNT    = 3'd2;
  localparam logic [2:0] STAT_LONG    = 3'd3;
  localparam logic [2:0] STAT_PHYERR  = 3'd4;
  localparam logic [2:0] STAT_TIMEOUT = 3'd5;

  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [7:0] PRE_BYTE = 8'h55;

  localparam int CHK_TIMEOUT = 4;
  localparam int LEN_W       = 11;
endpackage

// File: rtl/gmii_rx_frame_ctrl_if.sv
// GMII receive, CRC checker and frame/status buses of the receive frame controller.
interface gmii_rx_frame_ctrl_if;
  import eth_rx_pkg::*;
  logic             rx_dv;
  logic             rx_er;
  logic [7:0]       rxd;
  logic             crc_dsin;
  logic [7:0]       crc_din;
  logic             crc_cal_end;
  logic             crc_error;
  logic [7:0]       frm_data;
  logic             frm_valid;
  logic             frm_sof;
  logic             stat_valid;
  logic             stat_ok;
  logic [2:0]       stat_code;
  logic [LEN_W-1:0] stat_len;

  modport master (
    input  rx_dv, rx_er, rxd, crc_cal_end, crc_error,
    output crc_dsin, crc_din, frm_data, frm_valid, frm_sof,
           stat_valid, stat_ok, stat_code, stat_len
  );
  modport slave (
    output rx_dv, rx_er, rxd, crc_cal_end, crc_error,
    input  crc_dsin, crc_din, frm_data, frm_valid, frm_sof,
           stat_valid, stat_ok, stat_code, stat_len
  );
endinterface

// File: rtl/gmii_rx_frame_ctrl_fcs_strip_dly.sv
// Four-stage byte delay that holds back the last four bytes of a frame (the FCS).
module fcs_strip_dly (
  input  logic       sclk,
  input  logic       resetb,
  input  logic       in_vld,
  input  logic       in_sof,
  input  logic [7:0] in_data,
  input  logic       flush,
  output logic       out_vld,
  output logic       out_sof,
  output logic [7:0] out_data
);
  logic [7:0] dat_p [4];
  logic [3:0] vld_p;
  logic [3:0] sof_p;

  always_ff @(posedge sclk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < 4; i++) dat_p[i] <= '0;
      vld_p    <= '0;
      sof_p    <= '0;
      out_vld  <= 1'b0;
      out_sof  <= 1'b0;
      out_data <= '0;
    end else if (flush) begin
      vld_p   <= '0;
      sof_p   <= '0;
      out_vld <= 1'b0;
      out_sof <= 1'b0;
    end else if (in_vld) begin
      // a byte leaves only when a new byte pushes it out of the last stage
      dat_p[0] <= in_data;
      for (int i = 1; i < 4; i++) dat_p[i] <= dat_p[i-1];
      vld_p   <= {vld_p[2:0], 1'b1};
      sof_p   <= {sof_p[2:0], in_sof};
      out_vld <= vld_p[3];
      out_sof <= sof_p[3];
      if (vld_p[3]) out_data <= dat_p[3];
    end else begin
      out_vld <= 1'b0;
      out_sof <= 1'b0;
    end
  end
endmodule

// File: rtl/gmii_rx_frame_ctrl.sv
// GMII receive frame controller: preamble/SFD detect, CRC checker sequencing, per-frame status.
// Optional RX_FCS_STRIP_EN removes the 4 FCS bytes from the frm_* stream.
module gmii_rx_frame_ctrl
  import eth_rx_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int PRE_MAX = 7
) (
  input  logic                 sclk,
  input  logic                 resetb,
  gmii_rx_frame_ctrl_if.master bus
);
  localparam logic [3:0]       PRE_LAST = 4'(PRE_MAX);
  localparam logic [2:0]       CHK_LAST = 3'(CHK_TIMEOUT - 1);
  localparam logic [LEN_W-1:0] MIN_L    = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_t           state, state_nx;
  logic [3:0]       pre_cnt, pre_cnt_nx;
  logic [LEN_W-1:0] len, len_nx;
  logic [2:0]       chk_cnt, chk_cnt_nx;
  logic             phy_err, phy_err_nx;
  logic             crc_err, crc_err_nx;
  logic             tmo, tmo_nx;
  logic             fwd;
  logic [2:0]       code_nx;

  function automatic logic [2:0] status_code(input logic perr, input logic tout,
                                             input logic cerr, input logic [LEN_W-1:0] n);
    if (perr)           return STAT_PHYERR;
    else if (tout)      return STAT_TIMEOUT;
    else if (cerr)      return STAT_CRC;
    else if (n < MIN_L) return STAT_RUNT;
    else if (n > MAX_L) return STAT_LONG;
    else                return STAT_OK;
  endfunction

  always_ff @(posedge sclk or negedge resetb) begin
    if (!resetb) begin
      state   <= ST_IDLE;
      pre_cnt <= '0;
      len     <= '0;
      chk_cnt <= '0;
      phy_err <= 1'b0;
      crc_err <= 1'b0;
      tmo     <= 1'b0;
    end else begin
      state   <= state_nx;
      pre_cnt <= pre_cnt_nx;
      len     <= len_nx;
      chk_cnt <= chk_cnt_nx;
      phy_err <= phy_err_nx;
      crc_err <= crc_err_nx;
      tmo     <= tmo_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pre_cnt_nx = pre_cnt;
    len_nx     = len;
    chk_cnt_nx = chk_cnt;
    phy_err_nx = phy_err;
    crc_err_nx = crc_err;
    tmo_nx     = tmo;
    fwd        = 1'b0;
    case (state)
      ST_IDLE: if (bus.rx_dv && bus.rxd == PRE_BYTE) begin
        state_nx   = ST_PRE;
        pre_cnt_nx = 4'd1;
        len_nx     = '0;
        phy_err_nx = 1'b0;
        crc_err_nx = 1'b0;
        tmo_nx     = 1'b0;
      end
      ST_PRE: begin
        if (!bus.rx_dv)                state_nx = ST_IDLE;
        else if (bus.rx_er)            state_nx = ST_DROP;
        else if (bus.rxd == PRE_BYTE) begin
          if (pre_cnt >= PRE_LAST)     state_nx = ST_DROP;
          else                         pre_cnt_nx = pre_cnt + 4'd1;
        end
        else if (bus.rxd == SFD_BYTE)  state_nx = ST_DATA;
        else                           state_nx = ST_DROP;
      end
      ST_DATA: begin
        if (bus.rx_dv) begin
          fwd = 1'b1;
          if (len != '1) len_nx = len + LEN_ONE;
          if (bus.rx_er) phy_err_nx = 1'b1;
        end else if (len != '0) begin
          state_nx   = ST_CHECK;
          chk_cnt_nx = '0;
        end else begin
          // empty frame: checker was never strobed, so no result to wait for
          state_nx = ST_STATUS;
        end
      end
      ST_CHECK: begin
        if (bus.crc_cal_end) begin
          crc_err_nx = bus.crc_error;
          state_nx   = ST_STATUS;
        end else if (chk_cnt == CHK_LAST) begin
          tmo_nx   = 1'b1;
          state_nx = ST_STATUS;
        end else begin
          chk_cnt_nx = chk_cnt + 3'd1;
        end
      end
      ST_STATUS: state_nx = ST_IDLE;
      ST_DROP:   if (!bus.rx_dv) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
    code_nx = status_code(phy_err_nx, tmo_nx, crc_err_nx, len_nx);
  end

  // stage p0: checker strobe and status word registered off the next-state decode
  always_ff @(posedge sclk or negedge resetb) begin
    if (!resetb) begin
      bus.crc_dsin   <= 1'b0;
      bus.crc_din    <= '0;
      bus.stat_valid <= 1'b0;
      bus.stat_ok    <= 1'b0;
      bus.stat_code  <= '0;
      bus.stat_len   <= '0;
    end else begin
      bus.crc_dsin   <= fwd;
      if (fwd) bus.crc_din <= bus.rxd;
      bus.stat_valid <= (state_nx == ST_STATUS);
      if (state_nx == ST_STATUS) begin
        bus.stat_code <= code_nx;
        bus.stat_ok   <= (code_nx == STAT_OK);
        bus.stat_len  <= len_nx;
      end
    end
  end

  logic       frm_valid_w;
  logic       frm_sof_w;
  logic [7:0] frm_data_w;

`ifdef RX_FCS_STRIP_EN
  fcs_strip_dly u_strip (
    .sclk     (sclk),
    .resetb   (resetb),
    .in_vld   (fwd),
    .in_sof   (fwd && len == '0),
    .in_data  (bus.rxd),
    .flush    (!fwd),
    .out_vld  (frm_valid_w),
    .out_sof  (frm_sof_w),
    .out_data (frm_data_w)
  );
`else
  always_ff @(posedge sclk or negedge resetb) begin
    if (!resetb) begin
      frm_valid_w <= 1'b0;
      frm_sof_w   <= 1'b0;
      frm_data_w  <= '0;
    end else begin
      frm_valid_w <= fwd;
      frm_sof_w   <= fwd && (len == '0);
      if (fwd) frm_data_w <= bus.rxd;
    end
  end
`endif

  assign bus.frm_valid = frm_valid_w;
  assign bus.frm_sof   = frm_sof_w;
  assign bus.frm_data  = frm_data_w;
endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Bench for gmii_rx_frame_ctrl: CRC-32 checker model, status scoreboard, per-scenario tasks.
module tb_gmii_rx_frame_ctrl;
  import eth_rx_pkg::*;

`ifdef RX_FCS_STRIP_EN
  localparam int STRIP = 4;
`else
  localparam int STRIP = 0;
`endif

  logic sclk = 1'b0;
  logic resetb = 1'b0;
  always #5 sclk = ~sclk;

  gmii_rx_frame_ctrl_if bus ();
  gmii_rx_frame_ctrl dut (.sclk(sclk), .resetb(resetb), .bus(bus));

  typedef struct {
    logic [2:0]  code;
    logic        ok;
    logic [10:0] len;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] frame[$];
  int         n_chk = 0;
  int         n_pass = 0;
  bit         chk_mute = 1'b0;

  function automatic exp_t mk(input logic [2:0] code, input int len);
    exp_t e;
    e.code = code;
    e.ok   = (code == STAT_OK);
    e.len  = 11'(len);
    return e;
  endfunction

  function automatic logic [31:0] crc32(input logic [7:0] q[$], input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic bit fcs_good(input logic [7:0] q[$]);
    int n = q.size();
    logic [31:0] c;
    if (n < 4) return 1'b0;
    c = ~crc32(q, n - 4);
    return {q[n-1], q[n-2], q[n-3], q[n-4]} == c;
  endfunction

  // checker model: collects strobed bytes, answers one cycle after the strobe falls
  logic       dsin_q;
  logic [7:0] seen[$];
  always @(posedge sclk or negedge resetb) begin
    if (!resetb) begin
      dsin_q          <= 1'b0;
      bus.crc_cal_end <= 1'b0;
      bus.crc_error   <= 1'b0;
      seen.delete();
    end else begin
      bus.crc_cal_end <= 1'b0;
      dsin_q          <= bus.crc_dsin;
      if (bus.crc_dsin) seen.push_back(bus.crc_din);
      if (dsin_q && !bus.crc_dsin) begin
        if (!chk_mute) begin
          bus.crc_cal_end <= 1'b1;
          bus.crc_error   <= !fcs_good(seen);
        end
        seen.delete();
      end
    end
  end

  int         dsin_cnt = 0, frm_cnt = 0, sof_cnt = 0, stat_cnt = 0;
  logic [7:0] frm_buf[4096];
  always @(negedge sclk) begin
    if (bus.crc_dsin) dsin_cnt <= dsin_cnt + 1;
    if (bus.frm_valid) begin
      frm_buf[frm_cnt % 4096] <= bus.frm_data;
      frm_cnt <= frm_cnt + 1;
    end
    if (bus.frm_valid && bus.frm_sof) sof_cnt <= sof_cnt + 1;
    if (bus.stat_valid) stat_cnt <= stat_cnt + 1;
  end

  task automatic build_frame(input int len, input bit good);
    logic [31:0] c;
    frame.delete();
    for (int i = 0; i < len - 4; i++) frame.push_back(8'($urandom_range(0, 255)));
    c = ~crc32(frame, len - 4);
    frame.push_back(c[7:0]);   frame.push_back(c[15:8]);
    frame.push_back(c[23:16]); frame.push_back(c[31:24]);
    if (!good) frame[10] = frame[10] ^ 8'h04;
  endtask

  task automatic drive_pkt(input int npre, input logic [7:0] sfd, input int er_at);
    for (int i = 0; i < npre; i++) begin
      @(negedge sclk); bus.rx_dv = 1'b1; bus.rx_er = 1'b0; bus.rxd = PRE_BYTE;
    end
    @(negedge sclk); bus.rxd = sfd;
    for (int i = 0; i < frame.size(); i++) begin
      @(negedge sclk); bus.rxd = frame[i]; bus.rx_er = (i == er_at);
    end
    @(negedge sclk); bus.rx_dv = 1'b0; bus.rx_er = 1'b0; bus.rxd = 8'h00;
  endtask

  // lat = clock edges from the first rx_dv=0 sample until stat_valid is seen, -1 if never
  task automatic send(input int npre, input logic [7:0] sfd, input int er_at, output int lat);
    drive_pkt(npre, sfd, er_at);
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge sclk); #1;
      if (bus.stat_valid) lat = c;
    end
  endtask

  task automatic test_reset;
    bus.rx_dv = 1'b0; bus.rx_er = 1'b0; bus.rxd = 8'h00;
    resetb = 1'b0;
    repeat (3) @(negedge sclk);
    n_chk++;
    if ({bus.crc_dsin, bus.crc_din, bus.frm_data, bus.frm_valid, bus.frm_sof, bus.stat_valid,
         bus.stat_ok, bus.stat_code, bus.stat_len} !== 35'd0)
      $display("FAIL reset_outputs: got dsin=%b din=%h frm=%h fv=%b sv=%b code=%0d len=%0d want all 0",
               bus.crc_dsin, bus.crc_din, bus.frm_data, bus.frm_valid, bus.stat_valid,
               bus.stat_code, bus.stat_len);
    else n_pass++;
    resetb = 1'b1;
    repeat (2) @(negedge sclk);
  endtask

  task automatic test_good;
    int lat, b_d, b_f, b_s, bad;
    exp_t e;
    build_frame(64, 1'b1);
    sb.push_back(mk(STAT_OK, 64));
    b_d = dsin_cnt; b_f = frm_cnt; b_s = sof_cnt;
    send(7, SFD_BYTE, -1, lat);
    e = sb.pop_front();
    n_chk++;
    if (lat !== 3) $display("FAIL good_latency: got %0d want 3", lat); else n_pass++;
    n_chk++;
    if ({bus.stat_code, bus.stat_ok, bus.stat_len} !== {e.code, e.ok, e.len})
      $display("FAIL good_status: got code=%0d ok=%b len=%0d want code=%0d ok=%b len=%0d",
               bus.stat_code, bus.stat_ok, bus.stat_len, e.code, e.ok, e.len);
    else n_pass++;
    @(negedge sclk); #1;
    n_chk++;
    if (dsin_cnt - b_d !== 64) $display("FAIL good_dsin_cycles: got %0d want 64", dsin_cnt - b_d);
    else n_pass++;
    n_chk++;
    if (frm_cnt - b_f !== 64 - STRIP)
      $display("FAIL good_frm_valid_cycles: got %0d want %0d", frm_cnt - b_f, 64 - STRIP);
    else n_pass++;
    n_chk++;
    if (sof_cnt - b_s !== 1) $display("FAIL good_sof_count: got %0d want 1", sof_cnt - b_s);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 64 - STRIP; i++) if (frm_buf[(b_f + i) % 4096] !== frame[i]) bad++;
    n_chk++;
    if (bad != 0) $display("FAIL good_frm_bytes: got %0d wrong bytes want 0", bad); else n_pass++;
  endtask

  task automatic test_crc;
    int lat;
    exp_t e;
    build_frame(64, 1'b0);
    sb.push_back(mk(STAT_CRC, 64));
    send(7, SFD_BYTE, -1, lat);
    e = sb.pop_front();
    n_chk++;
    if (lat < 0 || {bus.stat_code, bus.stat_ok, bus.stat_len} !== {e.code, e.ok, e.len})
      $display("FAIL crc_status: got lat=%0d code=%0d ok=%b len=%0d want code=%0d ok=%b len=%0d",
               lat, bus.stat_code, bus.stat_ok, bus.stat_len, e.code, e.ok, e.len);
    else n_pass++;
    repeat (4) @(negedge sclk);
  endtask

  task automatic test_runt;
    int lat, b_d;
    exp_t e;
    build_frame(60, 1'b1);
    sb.push_back(mk(STAT_RUNT, 60));
    send(7, SFD_BYTE, -1, lat);
    e = sb.pop_front();
    n_chk++;
    if (lat < 0 || {bus.stat_code, bus.stat_ok, bus.stat_len} !== {e.code, e.ok, e.len})
      $display("FAIL runt60_status: got lat=%0d code=%0d ok=%b len=%0d want code=%0d ok=%b len=%0d",
               lat, bus.stat_code, bus.stat_ok, bus.stat_len, e.code, e.ok, e.len);
    else n_pass++;
    repeat (4) @(negedge sclk);
    frame.delete();
    sb.push_back(mk(STAT_RUNT, 0));
    b_d = dsin_cnt;
    send(7, SFD_BYTE, -1, lat);
    e = sb.pop_front();
    n_chk++;
    if (lat < 0 || {bus.stat_code, bus.stat_ok, bus.stat_len} !== {e.code, e.ok, e.len})
      $display("FAIL runt0_status: got lat=%0d code=%0d ok=%b len=%0d want code=%0d ok=%b len=%0d",
               lat, bus.stat_code, bus.stat_ok, bus.stat_len, e.code, e.ok, e.len);
    else n_pass++;
    @(negedge sclk); #1;
    n_chk++;
    if (dsin_cnt != b_d) $display("FAIL runt0_dsin: got %0d strobes want 0", dsin_cnt - b_d);
    else n_pass++;
    repeat (4) @(negedge sclk);
  endtask

  task automatic test_long;
    int lat;
    exp_t e;
    build_frame(1519, 1'b1);
    sb.push_back(mk(STAT_LONG, 1519));
    send(7, SFD_BYTE, -1, lat);
    e = sb.pop_front();
    n_chk++;
    if (lat < 0 || {bus.stat_code, bus.stat_ok, bus.stat_len} !== {e.code, e.ok, e.len})
      $display("FAIL long_status: got lat=%0d code=%0d ok=%b len=%0d want code=%0d ok=%b len=%0d",
               lat, bus.stat_code, bus.stat_ok, bus.stat_len, e.code, e.ok, e.len);
    else n_pass++;
    repeat (4) @(negedge sclk);
    build_frame(1519, 1'b0);
    sb.push_back(mk(STAT_PHYERR, 1519));
    send(7, SFD_BYTE, 700, lat);
    e = sb.pop_front();
    n_chk++;
    if (lat < 0 || {bus.stat_code, bus.stat_ok, bus.stat_len} !== {e.code, e.ok, e.len})
      $display("FAIL phyerr_status: got lat=%0d code=%0d ok=%b len=%0d want code=%0d ok=%b len=%0d",
               lat, bus.stat_code, bus.stat_ok, bus.stat_len, e.code, e.ok, e.len);
    else n_pass++;
    repeat (4) @(negedge sclk);
  endtask

  task automatic test_drop;
    int b_s, b_f;
    build_frame(64, 1'b1);
    b_s = stat_cnt; b_f = frm_cnt;
    drive_pkt(2, 8'h12, -1);
    repeat (8) @(negedge sclk);
    n_chk++;
    if (stat_cnt != b_s || frm_cnt != b_f)
      $display("FAIL drop_bad_pre: got %0d status %0d frm bytes want 0 0", stat_cnt - b_s, frm_cnt - b_f);
    else n_pass++;
    b_s = stat_cnt; b_f = frm_cnt;
    drive_pkt(8, SFD_BYTE, -1);
    repeat (8) @(negedge sclk);
    n_chk++;
    if (stat_cnt != b_s || frm_cnt != b_f)
      $display("FAIL drop_long_pre: got %0d status %0d frm bytes want 0 0", stat_cnt - b_s, frm_cnt - b_f);
    else n_pass++;
    n_chk++;
    if ({bus.stat_code, bus.stat_len} !== {STAT_PHYERR, 11'd1519})
      $display("FAIL status_hold: got code=%0d len=%0d want code=4 len=1519", bus.stat_code, bus.stat_len);
    else n_pass++;
  endtask

  task automatic test_timeout;
    int lat;
    exp_t e;
    chk_mute = 1'b1;
    build_frame(64, 1'b1);
    sb.push_back(mk(STAT_TIMEOUT, 64));
    send(7, SFD_BYTE, -1, lat);
    e = sb.pop_front();
    n_chk++;
    if (lat < 1 || lat > 6) $display("FAIL timeout_latency: got %0d want 1..6", lat); else n_pass++;
    n_chk++;
    if ({bus.stat_code, bus.stat_ok, bus.stat_len} !== {e.code, e.ok, e.len})
      $display("FAIL timeout_status: got code=%0d ok=%b len=%0d want code=%0d ok=%b len=%0d",
               bus.stat_code, bus.stat_ok, bus.stat_len, e.code, e.ok, e.len);
    else n_pass++;
    chk_mute = 1'b0;
    repeat (4) @(negedge sclk);
  endtask

  task automatic test_reset_mid;
    int lat, b_s;
    exp_t e;
    build_frame(64, 1'b1);
    b_s = stat_cnt;
    for (int i = 0; i < 7; i++) begin
      @(negedge sclk); bus.rx_dv = 1'b1; bus.rx_er = 1'b0; bus.rxd = PRE_BYTE;
    end
    @(negedge sclk); bus.rxd = SFD_BYTE;
    for (int i = 0; i < 20; i++) begin
      @(negedge sclk); bus.rxd = frame[i];
    end
    @(negedge sclk); resetb = 1'b0; bus.rx_dv = 1'b0; bus.rxd = 8'h00;
    #1;
    n_chk++;
    if ({bus.crc_dsin, bus.crc_din, bus.frm_data, bus.frm_valid, bus.frm_sof, bus.stat_valid,
         bus.stat_ok, bus.stat_code, bus.stat_len} !== 35'd0)
      $display("FAIL midreset_outputs: got dsin=%b din=%h frm=%h fv=%b code=%0d len=%0d want all 0",
               bus.crc_dsin, bus.crc_din, bus.frm_data, bus.frm_valid, bus.stat_code, bus.stat_len);
    else n_pass++;
    @(negedge sclk); resetb = 1'b1;
    repeat (10) @(negedge sclk);
    n_chk++;
    if (stat_cnt != b_s) $display("FAIL midreset_no_status: got %0d want 0", stat_cnt - b_s);
    else n_pass++;
    build_frame(64, 1'b1);
    sb.push_back(mk(STAT_OK, 64));
    send(7, SFD_BYTE, -1, lat);
    e = sb.pop_front();
    n_chk++;
    if (lat != 3 || {bus.stat_code, bus.stat_ok, bus.stat_len} !== {e.code, e.ok, e.len})
      $display("FAIL midreset_next_frame: got lat=%0d code=%0d ok=%b len=%0d want lat=3 code=%0d ok=%b len=%0d",
               lat, bus.stat_code, bus.stat_ok, bus.stat_len, e.code, e.ok, e.len);
    else n_pass++;
    repeat (4) @(negedge sclk);
  endtask

  initial begin
    test_reset();
    test_good();
    test_crc();
    test_runt();
    test_long();
    test_drop();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gmii_rx_frame_ctrl.md
# gmii_rx_frame_ctrl

GMII receive frame controller that sequences the byte-wide CRC-32 receive checker. It detects preamble/SFD, frames the MAC bytes (DA through FCS), and drives the checker's data-strobe window. It collects the checker's end/error result, applies length and PHY-error checks, and emits one status word per frame alongside a byte stream to the downstream buffer.

## Interface
- MIN_LEN, 64, minimum legal frame length in bytes, DA..FCS inclusive
- MAX_LEN, 1518, maximum legal frame length in bytes, DA..FCS inclusive
- PRE_MAX, 7, maximum number of 0x55 preamble bytes accepted before SFD
- sclk  in  1  clock; all logic on posedge
- resetb  in  1  reset, asynchronous, active-low
- rx_dv  in  1  GMII receive data valid
- rx_er  in  1  GMII receive error
- rxd  in  8  GMII receive data
- crc_dsin  out  1  checker data strobe; high for every byte DA..FCS, low otherwise
- crc_din  out  8  checker data byte
- crc_cal_end  in  1  checker one-cycle "result ready" pulse
- crc_error  in  1  checker result, valid with crc_cal_end
- frm_data  out  8  frame byte to buffer
- frm_valid  out  1  frm_data qualifier
- frm_sof  out  1  first byte of frame, coincident with frm_valid
- stat_valid  out  1  one-cycle status strobe, once per frame that reached SFD
- stat_ok  out  1  frame good; valid with stat_valid
- stat_code  out  3  0 OK, 1 CRC, 2 RUNT, 3 LONG, 4 PHYERR, 5 TIMEOUT
- stat_len  out  11  byte count DA..FCS, saturating at 2047

## Operation
- States: IDLE, PRE, DATA, CHECK, STATUS, DROP.
- IDLE: rx_dv=1 and rxd=0x55 -> PRE, with pre_cnt=1.
- PRE:
  - rxd=0x55: pre_cnt+1; if pre_cnt would exceed PRE_MAX -> DROP.
  - rxd=0xD5 -> DATA.
  - Any other byte, or rx_er=1 -> DROP.
  - rx_dv=0 -> IDLE.
  - No status is emitted from PRE or DROP.
- DATA, per byte with rx_dv=1:
  - len+1, saturating.
  - Byte is forwarded to crc_din/frm_data with crc_dsin=frm_valid=1.
  - rx_er=1 sets the sticky phy_err flag.
- DATA with rx_dv=0:
  - If len>0 -> CHECK.
  - If len=0 -> STATUS with code RUNT. The checker is never strobed, so no crc_cal_end is awaited.
- CHECK: waits for crc_cal_end, latches crc_error, -> STATUS. If no crc_cal_end arrives within 4 cycles -> STATUS with TIMEOUT.
- STATUS: drives stat_valid for one cycle, then -> IDLE.
  - Code priority: PHYERR > TIMEOUT > CRC > RUNT (len<MIN_LEN) > LONG (len>MAX_LEN) > OK.
  - stat_ok=1 only when code=OK.
- DROP: waits for rx_dv=0, then -> IDLE.
- rx_dv activity during CHECK/STATUS is ignored; detection restarts in IDLE on the next 0x55.
- resetb low at any point: state -> IDLE, counters and flags cleared, all outputs 0 immediately. A partial frame produces no status.

## Timing
- Reset value of every output is 0, including crc_din and frm_data.
- crc_dsin, crc_din, frm_data, frm_valid, frm_sof are registered: byte sampled at cycle n appears at n+1.
- End of frame:
  - rx_dv=0 sampled at cycle m.
  - crc_dsin falls at m+1.
  - The checker returns crc_cal_end at m+2.
  - stat_valid at m+3.
- Timeout: stat_valid no later than m+6.
- crc_dsin is never high for a byte outside DA..FCS. It always has exactly one falling edge per frame with len>0.
- stat_len/stat_code/stat_ok are held stable from stat_valid until the next stat_valid.

## Configuration
- RX_FCS_STRIP_EN defined:
  - The frm_* path passes through a 4-byte delay line.
  - A byte is emitted only when a following 4th byte arrives, so the 4 FCS bytes never assert frm_valid.
  - frm_sof accompanies the first emitted byte.
  - The delay line is flushed without output at frame end.
  - Latency for frm_* becomes n+5. crc_* timing is unchanged.
- RX_FCS_STRIP_EN undefined: frm_* carries all bytes DA..FCS, aligned with crc_*.
- stat_len includes the FCS in both cases.

## Structure
- Package eth_rx_pkg holds:
  - the state enum;
  - the stat_code constants (STAT_OK … STAT_TIMEOUT);
  - the SFD and preamble constants (0xD5, 0x55);
  - the CHECK timeout constant (4).
- One sub-module, fcs_strip_dly: 4-stage byte delay with valid/sof tracking and flush. It is instantiated only under RX_FCS_STRIP_EN.

## Test plan
- 7×0x55, 0xD5, 64-byte frame with correct FCS -> crc_dsin high 64 cycles; stat_valid 3 cycles after rx_dv falls; stat_ok=1, code 0, len 64.
- Same frame with one payload bit flipped -> stat_ok=0, code 1, len 64.
- 60-byte frame with valid FCS -> code 2, len 60. SFD immediately followed by rx_dv=0 -> code 2, len 0, crc_dsin never asserted.
- 1519-byte frame -> code 3. Same frame with rx_er pulsed mid-DATA and a bad FCS -> code 4.
- Preamble 0x55,0x55,0x12 -> DROP, no stat_valid, no frm_valid. 8×0x55 with PRE_MAX=7 -> DROP.
- resetb pulsed mid-DATA -> outputs 0 at once, no status; next clean frame -> code 0. Under RX_FCS_STRIP_EN, 64-byte frame -> exactly 60 frm_valid cycles.
